// File: rtl/tdm_demux3.sv
// Receive side of the 3-channel TDM link: tracks frame alignment from frame_sync
// and de-interleaves slots a/b/c into three atomically updated channel outputs.
module tdm_demux3 #(
    parameter int W        = 1,
    parameter int MISS_MAX = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] ch_a,
    output logic [W-1:0] ch_b,
    output logic [W-1:0] ch_c,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

    state_t       r_state;
    logic [1:0]   r_slot;
    logic [3:0]   r_miss;
    logic [W-1:0] r_sh_a;
    logic [W-1:0] r_sh_b;
    logic [W-1:0] r_ch_a;
    logic [W-1:0] r_ch_b;
    logic [W-1:0] r_ch_c;
    logic         r_frame_valid;
    logic         r_sync_err;
    logic [3:0]   w_miss_inc;

    assign w_miss_inc = r_miss + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= HUNT;
            r_slot        <= 2'd0;
            r_miss        <= 4'd0;
            r_sh_a        <= '0;
            r_sh_b        <= '0;
            r_ch_a        <= '0;
            r_ch_b        <= '0;
            r_ch_c        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    HUNT: begin
                        if (frame_sync) begin
                            r_sh_a  <= din;
                            r_slot  <= 2'd1;
                            r_miss  <= 4'd0;
                            r_state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (frame_sync) begin
                            // A sync anywhere restarts the frame; mid-frame it also flags misalignment.
                            if (r_slot != 2'd0)
                                r_sync_err <= 1'b1;
                            r_sh_a <= din;
                            r_slot <= 2'd1;
                            r_miss <= 4'd0;
                        end else if (r_slot == 2'd0) begin
                            if (w_miss_inc == MISS_LIM) begin
                                r_slot  <= 2'd0;
                                r_miss  <= 4'd0;
                                r_state <= HUNT;
                            end else begin
                                r_sh_a <= din;
                                r_slot <= 2'd1;
                                r_miss <= w_miss_inc;
                            end
                        end else if (r_slot == 2'd1) begin
                            r_sh_b <= din;
                            r_slot <= 2'd2;
                        end else begin
                            r_ch_a        <= r_sh_a;
                            r_ch_b        <= r_sh_b;
                            r_ch_c        <= din;
                            r_frame_valid <= 1'b1;
                            r_slot        <= 2'd0;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign ch_a        = r_ch_a;
    assign ch_b        = r_ch_b;
    assign ch_c        = r_ch_c;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == LOCKED);

endmodule

// File: tb/tb_tdm_demux3.sv
// Bench for tdm_demux3: directed scenarios plus a randomized run checked against
// a queue-based frame model.
module tb_tdm_demux3;

    localparam int W        = 1;
    localparam int MISS_MAX = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] ch_a, ch_b, ch_c;
    logic         frame_valid, locked, sync_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit           m_locked;
    int           m_miss;
    logic [W-1:0] m_q[$];
    logic [W-1:0] exp_a, exp_b, exp_c;
    logic         exp_fv, exp_se;

    tdm_demux3 #(.W(W), .MISS_MAX(MISS_MAX)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_locked = 0;
        m_miss   = 0;
        m_q      = {};
        exp_a = '0; exp_b = '0; exp_c = '0;
        exp_fv = 1'b0; exp_se = 1'b0;
    endtask

    task automatic model_step(input logic [W-1:0] d, input logic v, input logic fs);
        exp_fv = 1'b0;
        exp_se = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1; m_q = {d}; m_miss = 0;
            end
        end else if (fs) begin
            if (m_q.size() != 0) exp_se = 1'b1;
            m_q = {d}; m_miss = 0;
        end else if (m_q.size() == 0) begin
            m_miss++;
            if (m_miss == MISS_MAX) begin
                m_locked = 0; m_miss = 0;
            end else begin
                m_q = {d};
            end
        end else begin
            m_q.push_back(d);
            if (m_q.size() == 3) begin
                exp_a = m_q[0]; exp_b = m_q[1]; exp_c = m_q[2];
                exp_fv = 1'b1;
                m_q = {};
            end
        end
    endtask

    // Drive one cycle, clock it, then settle just past the edge for sampling.
    task automatic step(input logic [W-1:0] d, input logic v, input logic fs);
        din = d; din_valid = v; frame_sync = fs;
        @(posedge clk);
        model_step(d, v, fs);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0; frame_sync = 1'b0; din = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ch_a, ch_b, ch_c, frame_valid, locked, sync_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got ch=%b%b%b fv=%b lk=%b se=%b, want all 0",
                     ch_a, ch_b, ch_c, frame_valid, locked, sync_err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (locked !== 1'b1 || frame_valid !== 1'b0) begin
            n_errors++; $display("FAIL basic_lock: lk=%b fv=%b, want lk=1 fv=0", locked, frame_valid);
        end
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_errors++; $display("FAIL basic_early_fv: fv=%b, want 0", frame_valid);
        end
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || {ch_a, ch_b, ch_c} !== 3'b101) begin
            n_errors++; $display("FAIL basic_frame: fv=%b ch=%b%b%b, want fv=1 ch=101",
                                 frame_valid, ch_a, ch_b, ch_c);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b0 || {ch_a, ch_b, ch_c} !== 3'b101) begin
            n_errors++; $display("FAIL basic_pulse: fv=%b ch=%b%b%b, want fv=0 ch=101",
                                 frame_valid, ch_a, ch_b, ch_c);
        end
    endtask

    task automatic test_hunt();
        logic [W-1:0] words[3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        foreach (words[i]) begin
            step(words[i], 1'b1, 1'b0);
            n_checks++;
            if (locked !== 1'b0 || frame_valid !== 1'b0) begin
                n_errors++; $display("FAIL hunt_discard%0d: lk=%b fv=%b, want 0 0", i, locked, frame_valid);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++; $display("FAIL hunt_invalid_sync: lk=%b, want 0", locked);
        end
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++; $display("FAIL hunt_acquire: lk=%b, want 1", locked);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin
                n_errors++; $display("FAIL gaps_idle%0d: fv=%b se=%b, want 0 0", k, frame_valid, sync_err);
            end
        end
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || {ch_a, ch_b, ch_c} !== 3'b101 || locked !== 1'b1) begin
            n_errors++; $display("FAIL gaps_frame: fv=%b lk=%b ch=%b%b%b, want fv=1 lk=1 ch=101",
                                 frame_valid, locked, ch_a, ch_b, ch_c);
        end
    endtask

    task automatic test_sync_err();
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (sync_err !== 1'b0) begin
            n_errors++; $display("FAIL serr_slot0: se=%b, want 0", sync_err);
        end
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || {ch_a, ch_b, ch_c} !== 3'b101) begin
            n_errors++; $display("FAIL serr_pulse: se=%b fv=%b ch=%b%b%b, want se=1 fv=0 ch=101",
                                 sync_err, frame_valid, ch_a, ch_b, ch_c);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sync_err !== 1'b0) begin
            n_errors++; $display("FAIL serr_one_cycle: se=%b, want 0", sync_err);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || {ch_a, ch_b, ch_c} !== 3'b100) begin
            n_errors++; $display("FAIL serr_realign: fv=%b ch=%b%b%b, want fv=1 ch=100",
                                 frame_valid, ch_a, ch_b, ch_c);
        end
    endtask

    task automatic test_miss();
        do_reset();
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || locked !== 1'b1 || {ch_a, ch_b, ch_c} !== 3'b110) begin
            n_errors++; $display("FAIL miss_first_frame: fv=%b lk=%b ch=%b%b%b, want fv=1 lk=1 ch=110",
                                 frame_valid, locked, ch_a, ch_b, ch_c);
        end
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++; $display("FAIL miss_drop: lk=%b, want 0", locked);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b0 || locked !== 1'b0 || {ch_a, ch_b, ch_c} !== 3'b110) begin
            n_errors++; $display("FAIL miss_no_deliver: fv=%b lk=%b ch=%b%b%b, want fv=0 lk=0 ch=110",
                                 frame_valid, locked, ch_a, ch_b, ch_c);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({ch_a, ch_b, ch_c, frame_valid, locked, sync_err} !== '0) begin
            n_errors++; $display("FAIL rst_async: ch=%b%b%b fv=%b lk=%b se=%b, want all 0",
                                 ch_a, ch_b, ch_c, frame_valid, locked, sync_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b0 || locked !== 1'b0 || {ch_a, ch_b, ch_c} !== 3'b000) begin
            n_errors++; $display("FAIL rst_partial_dropped: fv=%b lk=%b ch=%b%b%b, want 0 0 000",
                                 frame_valid, locked, ch_a, ch_b, ch_c);
        end
    endtask

    task automatic test_random();
        int g = 0;
        logic [W-1:0] d;
        logic v, fs;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            d  = W'($urandom);
            v  = ($urandom_range(0, 9) < 7);
            fs = (g == 0);
            if ($urandom_range(0, 9) < 2) fs = ~fs;
            if (v) g = (g + 1) % 3;
            step(d, v, fs);
            n_checks++;
            if (frame_valid !== exp_fv || sync_err !== exp_se || locked !== m_locked ||
                ch_a !== exp_a || ch_b !== exp_b || ch_c !== exp_c) begin
                n_errors++;
                $display("FAIL random_cycle%0d: fv=%b se=%b lk=%b ch=%b%b%b, want fv=%b se=%b lk=%b ch=%b%b%b",
                         i, frame_valid, sync_err, locked, ch_a, ch_b, ch_c,
                         exp_fv, exp_se, m_locked, exp_a, exp_b, exp_c);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_hunt();
        test_gaps();
        test_sync_err();
        test_miss();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
